// File: rtl/unsigned_approx_mult_pkg.sv
// Shared constants and the reference definition of the approximated low-row sum.
package unsigned_approx_mult_pkg;

    localparam int DEF_W     = 8;
    localparam int DEF_L     = 4;
    localparam int DEF_PIPE  = 2;
    localparam int DEF_CNT_W = 16;
    localparam int DEF_PW    = 2 * DEF_W;

    // Widest operand the low-row function accepts; callers zero-extend.
    localparam int MAX_W     = 32;

    // Partial-product bit x[i] & y[j]; y indices outside [0, w-1] read as 0.
    function automatic logic pp_bit(input logic [MAX_W-1:0] x,
                                    input logic [MAX_W-1:0] y,
                                    input int i, input int j, input int w);
        logic [MAX_W-1:0] xs;
        logic [MAX_W-1:0] ys;
        if (j < 0 || j >= w) return 1'b0;
        xs = x >> i;
        ys = y >> j;
        return xs[0] & ys[0];
    endfunction

    // LOW: OR-compressed row pairs (2k, 2k+1), keeping columns w-1 .. 2k+w,
    // plus the unpaired top row for odd l over columns w-1 .. l+w-2.
    function automatic logic [2*MAX_W:0] low_rows_approx(input logic [MAX_W-1:0] x,
                                                         input logic [MAX_W-1:0] y,
                                                         input int w, input int l);
        logic [2*MAX_W:0] acc;
        logic [2*MAX_W:0] one;
        logic             t;
        acc = '0;
        one = {{(2*MAX_W){1'b0}}, 1'b1};
        for (int k = 0; 2*k + 1 < l; k++) begin
            for (int c = w - 1; c <= 2*k + w; c++) begin
                t = pp_bit(x, y, 2*k, c - 2*k, w) | pp_bit(x, y, 2*k + 1, c - 2*k - 1, w);
                if (t) acc = acc + (one << c);
            end
        end
        if (l % 2 == 1) begin
            for (int c = w - 1; c <= l + w - 2; c++) begin
                if (pp_bit(x, y, l - 1, c - l + 1, w)) acc = acc + (one << c);
            end
        end
        return acc;
    endfunction

endpackage

// File: rtl/unsigned_approx_mult_pipe_lowrows.sv
// Combinational LOW term from the approximated rows x[L-1:0] and y.
module approx_lowrows_pp
    import unsigned_approx_mult_pkg::*;
#(
    parameter int W = DEF_W,
    parameter int L = DEF_L,
    localparam int XL = (L > 0) ? L : 1
) (
    input  logic [XL-1:0] i_x_low,
    input  logic [W-1:0]  i_y,
    output logic [2*W:0]  o_low
);

    logic [MAX_W-1:0] w_x_ext;
    logic [MAX_W-1:0] w_y_ext;

    assign w_x_ext = MAX_W'(i_x_low);
    assign w_y_ext = MAX_W'(i_y);

    // Same function the bench model uses, so there is one definition of LOW.
    always_comb begin
        o_low = (2*W+1)'(low_rows_approx(w_x_ext, w_y_ext, W, L));
    end

endmodule

// File: rtl/unsigned_approx_mult_pipe.sv
// Pipelined W x W unsigned multiplier with runtime exact/approximate selection,
// valid/ready flow control and a saturating approximate-transaction counter.
module unsigned_approx_mult_pipe
    import unsigned_approx_mult_pkg::*;
#(
    parameter int W     = DEF_W,
    parameter int L     = DEF_L,
    parameter int PIPE  = DEF_PIPE,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     x,
    input  logic [W-1:0]     y,
    input  logic             approx_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*W-1:0]   z,
    output logic             z_approx,
    output logic [CNT_W-1:0] approx_cnt,
    input  logic             cnt_clr
);

    localparam int PW   = 2 * W;
    localparam int SW   = PW + 1;
    localparam int XL   = (L > 0) ? L : 1;
    localparam int NDLY = (PIPE > 1) ? PIPE - 1 : 1;

    logic             w_adv;
    logic [SW-1:0]    w_hi;
    logic [SW-1:0]    w_low;

    // Inputs to the final (summing) stage.
    logic             w_f_v;
    logic [SW-1:0]    w_f_hi;
    logic [SW-1:0]    w_f_low;
    logic [W-1:0]     w_f_x;
    logic [W-1:0]     w_f_y;
    logic             w_f_m;

    logic             r_out_v;
    logic [PW-1:0]    r_z;
    logic             r_za;
    logic [CNT_W-1:0] r_cnt;

    assign w_adv      = !r_out_v || out_ready;
    assign in_ready   = w_adv;
    assign out_valid  = r_out_v;
    assign z          = r_z;
    assign z_approx   = r_za;
    assign approx_cnt = r_cnt;

    // Exact high rows x[W-1:L] shifted back into place; zero when L = W.
    assign w_hi = (SW'(y) * SW'(x >> L)) << L;

    approx_lowrows_pp #(.W(W), .L(L)) u_lowrows (
        .i_x_low (x[XL-1:0]),
        .i_y     (y),
        .o_low   (w_low)
    );

    generate
        if (PIPE == 1) begin : g_single
            assign w_f_v   = in_valid;
            assign w_f_hi  = w_hi;
            assign w_f_low = w_low;
            assign w_f_x   = x;
            assign w_f_y   = y;
            assign w_f_m   = approx_en;
        end else begin : g_chain
            logic          r_v   [NDLY];
            logic [SW-1:0] r_hi  [NDLY];
            logic [SW-1:0] r_low [NDLY];
            logic [W-1:0]  r_x   [NDLY];
            logic [W-1:0]  r_y   [NDLY];
            logic          r_m   [NDLY];

            // Stage 1 captures partial results; later entries are plain delays.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < NDLY; i++) begin
                        r_v[i]   <= 1'b0;
                        r_hi[i]  <= '0;
                        r_low[i] <= '0;
                        r_x[i]   <= '0;
                        r_y[i]   <= '0;
                        r_m[i]   <= 1'b0;
                    end
                end else if (w_adv) begin
                    r_v[0] <= in_valid;
                    if (in_valid) begin
                        r_hi[0]  <= w_hi;
                        r_low[0] <= w_low;
                        r_x[0]   <= x;
                        r_y[0]   <= y;
                        r_m[0]   <= approx_en;
                    end
                    for (int i = 1; i < NDLY; i++) begin
                        r_v[i] <= r_v[i-1];
                        if (r_v[i-1]) begin
                            r_hi[i]  <= r_hi[i-1];
                            r_low[i] <= r_low[i-1];
                            r_x[i]   <= r_x[i-1];
                            r_y[i]   <= r_y[i-1];
                            r_m[i]   <= r_m[i-1];
                        end
                    end
                end
            end

            assign w_f_v   = r_v[NDLY-1];
            assign w_f_hi  = r_hi[NDLY-1];
            assign w_f_low = r_low[NDLY-1];
            assign w_f_x   = r_x[NDLY-1];
            assign w_f_y   = r_y[NDLY-1];
            assign w_f_m   = r_m[NDLY-1];
        end
    endgenerate

    // Output stage: selects the exact or approximate sum; holds while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_v <= 1'b0;
            r_z     <= '0;
            r_za    <= 1'b0;
        end else if (w_adv) begin
            r_out_v <= w_f_v;
            if (w_f_v) begin
                r_z  <= w_f_m ? PW'(w_f_hi + w_f_low) : PW'(w_f_x) * PW'(w_f_y);
                r_za <= w_f_m;
            end
        end
    end

    // Saturating count of accepted approximate transfers; clear has priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (cnt_clr) begin
            r_cnt <= '0;
        end else if (in_valid && w_adv && approx_en && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_unsigned_approx_mult_pipe.sv
// Scoreboard bench: directed checks on the default build, a 2-bit counter build,
// and randomized streams over several W/L/PIPE builds.
module tb_unsigned_approx_mult_pipe;
    import unsigned_approx_mult_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_z(input logic [31:0] xv, input logic [31:0] yv,
                                          input logic ae, input int w, input int l);
        logic [63:0] hi, lo, ex, mask;
        mask = (64'd1 << (2*w)) - 64'd1;
        ex   = {32'b0, xv} * {32'b0, yv};
        hi   = ({32'b0, yv} * ({32'b0, xv} >> l)) << l;
        lo   = 64'(low_rows_approx(xv, yv, w, l));
        return (ae ? hi + lo : ex) & mask;
    endfunction

    logic g_rst_n;

    // ---------------- default build ----------------
    logic        m_rst_n, m_iv, m_ir, m_ae, m_ov, m_or, m_za, m_clr;
    logic [7:0]  m_x, m_y;
    logic [15:0] m_z, m_cnt;
    logic [16:0] m_q[$];

    unsigned_approx_mult_pipe #(.W(8), .L(4), .PIPE(2), .CNT_W(16)) u_main (
        .clk(clk), .rst_n(m_rst_n), .in_valid(m_iv), .in_ready(m_ir), .x(m_x), .y(m_y),
        .approx_en(m_ae), .out_valid(m_ov), .out_ready(m_or), .z(m_z), .z_approx(m_za),
        .approx_cnt(m_cnt), .cnt_clr(m_clr)
    );

    // ---------------- 2-bit counter build ----------------
    logic        s_iv, s_ir, s_ae, s_ov, s_or, s_za, s_clr;
    logic [7:0]  s_x, s_y;
    logic [15:0] s_z;
    logic [1:0]  s_cnt;

    unsigned_approx_mult_pipe #(.W(8), .L(4), .PIPE(1), .CNT_W(2)) u_sat (
        .clk(clk), .rst_n(g_rst_n), .in_valid(s_iv), .in_ready(s_ir), .x(s_x), .y(s_y),
        .approx_en(s_ae), .out_valid(s_ov), .out_ready(s_or), .z(s_z), .z_approx(s_za),
        .approx_cnt(s_cnt), .cnt_clr(s_clr)
    );

    // ---------------- randomized parameter sweep ----------------
    for (genvar gi = 0; gi < 12; gi++) begin : g_sw
        localparam int SW = (gi / 4 == 0) ? 4 : (gi / 4 == 1) ? 8 : 12;
        localparam int SL = (gi % 4 == 0) ? 0 : (gi % 4 == 1) ? 3 : (gi % 4 == 2) ? 4 : SW;
        localparam int SP = 1 + ((gi % 4) + (gi / 4)) % 4;

        logic            iv, ir, ov, ordy, za, ae, clr;
        logic [SW-1:0]   x, y;
        logic [2*SW-1:0] z;
        logic [7:0]      cnt;
        logic [2*SW:0]   q[$];

        unsigned_approx_mult_pipe #(.W(SW), .L(SL), .PIPE(SP), .CNT_W(8)) u_dut (
            .clk(clk), .rst_n(g_rst_n), .in_valid(iv), .in_ready(ir), .x(x), .y(y),
            .approx_en(ae), .out_valid(ov), .out_ready(ordy), .z(z), .z_approx(za),
            .approx_cnt(cnt), .cnt_clr(clr)
        );

        initial begin
            logic [63:0]   e;
            logic [2*SW:0] exp_v;
            iv = 1'b0; ordy = 1'b0; ae = 1'b0; x = '0; y = '0; clr = 1'b0;
            wait (g_rst_n === 1'b1);
            for (int c = 0; c < 330; c++) begin
                @(negedge clk);
                if (c < 300) begin
                    iv = ($urandom_range(0, 3) != 0);
                    x  = SW'($urandom);
                    y  = SW'($urandom);
                    ae = 1'($urandom);
                end else begin
                    iv = 1'b0;
                end
                ordy = (c >= 300) || ($urandom_range(0, 3) != 0);
                #1;
                if (ov && ordy) begin
                    check_eq("sw_nonempty", 64'(q.size() != 0), 64'd1);
                    if (q.size() != 0) begin
                        exp_v = q.pop_front();
                        check_eq($sformatf("sw_w%0d_l%0d_p%0d_z", SW, SL, SP), 64'({za, z}), 64'(exp_v));
                    end
                end
                if (iv && ir) begin
                    e = ref_z(32'(x), 32'(y), ae, SW, SL);
                    q.push_back({ae, e[2*SW-1:0]});
                end
            end
            check_eq($sformatf("sw_w%0d_l%0d_left", SW, SL), 64'(q.size()), 64'd0);
        end
    end

    // One transfer on the default build, checked at exactly two cycles latency.
    task automatic single(input string tag, input logic [7:0] xv, input logic [7:0] yv,
                          input logic ae, input logic [15:0] z_exp, input logic [15:0] cnt_exp);
        @(negedge clk);
        m_x = xv; m_y = yv; m_ae = ae; m_iv = 1'b1; m_or = 1'b1;
        #1 check_eq({tag, "_rdy"}, 64'(m_ir), 64'd1);
        @(negedge clk);
        m_iv = 1'b0;
        #1 check_eq({tag, "_lat"}, 64'(m_ov), 64'd0);
        @(negedge clk);
        #1;
        check_eq({tag, "_ov"}, 64'(m_ov), 64'd1);
        check_eq({tag, "_z"}, 64'(m_z), 64'(z_exp));
        check_eq({tag, "_za"}, 64'(m_za), 64'(ae));
        check_eq({tag, "_cnt"}, 64'(m_cnt), 64'(cnt_exp));
    endtask

    initial begin
        logic [63:0] e;
        logic [16:0] exp_v;
        logic [15:0] held;
        logic        stall_prev;
        int          sent, got, cyc;
        logic        seen;

        g_rst_n = 1'b0; m_rst_n = 1'b0;
        m_iv = 1'b0; m_x = '0; m_y = '0; m_ae = 1'b0; m_or = 1'b1; m_clr = 1'b0;
        s_iv = 1'b0; s_x = '0; s_y = '0; s_ae = 1'b0; s_or = 1'b1; s_clr = 1'b0;
        #2;
        check_eq("rst_ov", 64'(m_ov), 64'd0);
        check_eq("rst_z", 64'(m_z), 64'd0);
        check_eq("rst_za", 64'(m_za), 64'd0);
        check_eq("rst_cnt", 64'(m_cnt), 64'd0);
        check_eq("rst_ready", 64'(m_ir), 64'd1);
        @(negedge clk);
        g_rst_n = 1'b1; m_rst_n = 1'b1;

        single("exact_ff", 8'hFF, 8'hFF, 1'b0, 16'hFE01, 16'd0);
        single("apx_0f",   8'h0F, 8'hFF, 1'b1, 16'h0900, 16'd1);
        single("apx_f0",   8'hF0, 8'hA5, 1'b1, 16'h9AB0, 16'd2);

        // Six back-to-back transfers with the consumer stalling on cycles 3-5.
        sent = 0; got = 0; cyc = 0; stall_prev = 1'b0; held = '0;
        while (got < 6 && cyc < 40) begin
            @(negedge clk);
            m_or = !(cyc >= 3 && cyc <= 5);
            m_iv = (sent < 6);
            m_x  = 8'($urandom);
            m_y  = 8'($urandom);
            m_ae = 1'($urandom);
            #1;
            if (m_ov && !m_or) begin
                check_eq("stall_ready", 64'(m_ir), 64'd0);
                if (stall_prev) check_eq("stall_hold", 64'(m_z), 64'(held));
                held = m_z;
                stall_prev = 1'b1;
            end else begin
                stall_prev = 1'b0;
            end
            if (m_ov && m_or) begin
                check_eq("stream_nonempty", 64'(m_q.size() != 0), 64'd1);
                if (m_q.size() != 0) begin
                    exp_v = m_q.pop_front();
                    check_eq("stream_z", 64'({m_za, m_z}), 64'(exp_v));
                    got++;
                end
            end
            if (m_iv && m_ir) begin
                e = ref_z(32'(m_x), 32'(m_y), m_ae, 8, 4);
                m_q.push_back({m_ae, e[15:0]});
                sent++;
            end
            cyc++;
        end
        m_iv = 1'b0;
        check_eq("stream_count", 64'(got), 64'd6);
        check_eq("stream_left", 64'(m_q.size()), 64'd0);

        // Reset with two transactions in flight.
        @(negedge clk);
        m_iv = 1'b1; m_ae = 1'b1; m_or = 1'b1; m_x = 8'h37; m_y = 8'h91;
        @(negedge clk);
        m_x = 8'hC4; m_y = 8'h5A;
        @(negedge clk);
        m_iv = 1'b0;
        #2 m_rst_n = 1'b0;
        #1;
        check_eq("mid_rst_ov", 64'(m_ov), 64'd0);
        check_eq("mid_rst_cnt", 64'(m_cnt), 64'd0);
        check_eq("mid_rst_z", 64'(m_z), 64'd0);
        @(negedge clk);
        m_rst_n = 1'b1;
        m_iv = 1'b1; m_ae = 1'b0; m_x = 8'd3; m_y = 8'd5;
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            m_iv = 1'b0;
            #1;
            if (m_ov) begin
                seen = 1'b1;
                check_eq("post_rst_first_z", 64'(m_z), 64'd15);
            end
        end
        check_eq("post_rst_seen", 64'(seen), 64'd1);

        // Counter saturation on the 2-bit build, then clear against an increment.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            s_iv = 1'b1; s_ae = 1'b1; s_x = 8'h0F; s_y = 8'hFF;
            @(negedge clk);
            s_iv = 1'b0;
            #1;
            check_eq($sformatf("sat_cnt_%0d", i), 64'(s_cnt), 64'((i + 1 > 3) ? 3 : i + 1));
            if (i == 0) check_eq("p1_z", 64'(s_z), 64'h0900);
        end
        @(negedge clk);
        s_iv = 1'b1; s_ae = 1'b1; s_clr = 1'b1;
        @(negedge clk);
        s_iv = 1'b0; s_clr = 1'b0;
        #1 check_eq("clr_wins", 64'(s_cnt), 64'd0);

        // Let the sweep streams (bounded at 330 cycles each) run out.
        repeat (400) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/unsigned_approx_mult_pipe.md
Name: unsigned_approx_mult_pipe

Overview:
- Parametrised, pipelined unsigned W x W multiplier with approximate low partial-product rows.
- Successor to the fixed 8x8, l=4 combinational approximate multipliers.
- Adds runtime exact/approximate selection per transaction, valid/ready handshake with backpressure, and a saturating count of approximate transactions.
- Sits between operand producers and accumulation logic in the approximate-arithmetic datapaths.

Parameters:
- W, 8: operand width; W >= 2.
- L, 4: number of low rows of x that are approximated; 0 <= L <= W. L=0 means exact only.
- PIPE, 2: register stages, from input accept to output valid; 1 <= PIPE <= 4.
- CNT_W, 16: width of the approximate-transaction counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operands valid.
- in_ready  out  1  block can accept operands.
- x  in  W  multiplier operand; rows are indexed by bits of x.
- y  in  W  multiplicand operand.
- approx_en  in  1  1 = approximate product, 0 = exact product; sampled with the operands.
- out_valid  out  1  z valid.
- out_ready  in  1  consumer accepts z.
- z  out  2W  product.
- z_approx  out  1  approx_en that travelled with z.
- approx_cnt  out  CNT_W  accepted transactions with approx_en=1.
- cnt_clr  in  1  synchronous clear of approx_cnt.

Behaviour:
- Arithmetic:
  - Exact mode: z = x*y, full 2W bits.
  - Approx mode: z = (y * x[W-1:L]) << L, plus LOW.
- LOW, the approximation of rows i < L:
  - Partial-product bit p(i,j) = x[i] & y[j] at column i+j. Any y index outside [0, W-1] reads as 0.
  - Rows are paired as (2k, 2k+1). For column c, pair term t(k,c) = p(2k, c-2k) | p(2k+1, c-2k-1). The pair is OR-compressed, not added.
  - Only columns W-1 <= c <= 2k+W are kept. LOW = sum of t(k,c) * 2^c over all kept columns of all pairs.
  - Odd L: the final unpaired row L-1 contributes p(L-1, c-L+1) for W-1 <= c <= L+W-2.
  - L = 0: LOW = 0, and approx mode equals exact mode.
  - All sums are carried at 2W+1 bits internally; z is the low 2W bits (overflow is impossible for valid parameters).
- Pipeline:
  - Stage 1 registers the high-row product, LOW, the exact product operands and the mode.
  - The last stage registers the final sum.
  - Stages between these are plain delay registers.
  - Latency is exactly PIPE cycles from the accepting edge to out_valid=1, with no bubbles.
- Handshake:
  - Transfer in: in_valid & in_ready at a rising edge.
  - Transfer out: out_valid & out_ready at a rising edge.
  - Global enable: adv = !out_valid | out_ready.
  - in_ready = adv (combinational). When adv=0 every stage holds.
  - Each stage carries its own valid bit; empty stages propagate bubbles.
  - z and z_approx are stable while out_valid=1 and out_ready=0.
  - Throughput is 1 per cycle when out_ready stays high.
- Counter:
  - approx_cnt increments on each input transfer with approx_en=1.
  - Saturates at 2^CNT_W-1.
  - cnt_clr=1 forces 0 on the next edge; clear wins over a simultaneous increment.
- Reset (asynchronous, any time, including mid-pipeline):
  - All stage valids = 0 and in-flight data is discarded.
  - out_valid = 0, z = 0, z_approx = 0, approx_cnt = 0.
  - in_ready = 1 after reset, since out_valid = 0.
- After rst_n deasserts, the first transfer can occur on the first rising edge.

Decomposition:
- Package unsigned_approx_mult_pkg:
  - Default-parameter constants.
  - Product-width localparam (2W).
  - Function low_rows_approx(x, y, W, L) defining LOW. The RTL and the scoreboard model share this single definition.
- One combinational sub-module, approx_lowrows_pp (W, L): computes LOW from x[L-1:0] and y. Keeps the generate loops for pairs and columns out of the pipeline/handshake module.

Test Plan:
- Defaults, approx_en=0, x=8'hFF, y=8'hFF, out_ready=1 -> after 2 cycles: out_valid=1, z=16'hFE01, z_approx=0, approx_cnt=0.
- Defaults, approx_en=1, x=8'h0F, y=8'hFF -> z=2304 (16'h0900; exact is 3825); approx_cnt=1.
- Defaults, approx_en=1, x=8'hF0, y=8'hA5 -> z=16'h9AB0, equal to exact since the low rows are zero.
- Stream 6 back-to-back transfers, out_ready=0 on cycles 3-5 -> in_ready=0 while out_valid & !out_ready; z held stable; all 6 results delivered in order with none lost or duplicated.
- CNT_W=2: 5 approx transfers -> approx_cnt saturates at 3. Then cnt_clr together with an approx transfer -> approx_cnt=0.
- Assert rst_n=0 with 2 transactions in flight -> out_valid=0 and approx_cnt=0 immediately. After release, the next transfer is the first result seen.
- Sweep W in {4, 8, 12} and L in {0, 3, 4, W}, random x/y/approx_en -> z matches the package model in every case.
